// File: rtl/false_lock_detector_pkg.sv
// Shared FSM state encodings and magnitude constants for the false-lock detector.
package false_lock_detector_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MONITOR    = 3'd1,
    ST_DWELL      = 3'd2,
    ST_FALSE_LOCK = 3'd3,
    ST_RECOVER    = 3'd4
  } fl_state_e;

  localparam logic [15:0] MAG_SAT     = 16'h7FFF;
  localparam logic [15:0] MAG_MOST_NEG = 16'h8000;

endpackage

// File: rtl/false_lock_detector_leaky_mag_filter.sv
// Two-stage leaky integrator of |freqError|: stage 1 takes the magnitude and the
// error against the running average, stage 2 applies the Q0.16 gain and clamps.
module leaky_mag_filter
  import false_lock_detector_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sync_i,
  input  logic [15:0] freq_error_i,
  input  logic [15:0] alpha_i,
  output logic [15:0] avg_mag_o,
  output logic        avg_valid_o
);

  logic [15:0]        mag;
  logic signed [16:0] diff_d, diff_q;
  logic               mag_valid_q, avg_valid_q;
  logic [15:0]        avg_d, avg_q;
  logic signed [33:0] prod, step, sum;

  always_comb begin
    if (freq_error_i == MAG_MOST_NEG) mag = MAG_SAT;
    else if (freq_error_i[15])        mag = 16'(-freq_error_i);
    else                              mag = freq_error_i;
  end

  assign diff_d = $signed({1'b0, mag}) - $signed({1'b0, avg_q});

  // Arithmetic shift rounds the step toward -inf, so a decaying average can reach 0.
  always_comb begin
    prod = $signed({{17{diff_q[16]}}, diff_q}) * $signed({18'b0, alpha_i});
    step = prod >>> 16;
    sum  = $signed({18'b0, avg_q}) + step;
    if (sum < 0)                  avg_d = '0;
    else if (sum > 34'sd65535)    avg_d = '1;
    else                          avg_d = sum[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      diff_q      <= '0;
      mag_valid_q <= 1'b0;
      avg_valid_q <= 1'b0;
      avg_q       <= '0;
    end else begin
      if (sync_i) diff_q <= diff_d;
      mag_valid_q <= sync_i;
      avg_valid_q <= mag_valid_q;
      if (mag_valid_q) avg_q <= avg_d;
    end
  end

  assign avg_mag_o   = avg_q;
  assign avg_valid_o = avg_valid_q;

endmodule

// File: rtl/false_lock_detector.sv
// False-lock detector: filtered error magnitude vs threshold with dwell/recover FSM.
// Optional FALSE_LOCK_STATS_EN adds clearStats / falseLockCount.
module false_lock_detector
  import false_lock_detector_pkg::*;
#(
  parameter int unsigned DWELL_COUNT = 64,
  parameter int unsigned RESET_PULSE = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sync,
  input  logic [15:0] freqError,
  input  logic        carrierLock,
  input  logic [15:0] falseLockAlpha,
  input  logic [15:0] falseLockThreshold,
  output logic [15:0] avgMag,
  output logic        highFreqOffset,
  output logic        loopReset
`ifdef FALSE_LOCK_STATS_EN
  ,
  input  logic        clearStats,
  output logic [15:0] falseLockCount
`endif
);

  localparam int unsigned PW = $clog2(RESET_PULSE + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_COUNT);
  localparam logic [PW-1:0]    PULSE_LAST = PW'(RESET_PULSE - 1);

  logic       avg_valid;
  logic       above, below;
  fl_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic       hfo_q, hfo_d, lr_q, lr_d;

  leaky_mag_filter u_filter (
    .clk          (clk),
    .reset_n      (reset_n),
    .sync_i       (sync),
    .freq_error_i (freqError),
    .alpha_i      (falseLockAlpha),
    .avg_mag_o    (avgMag),
    .avg_valid_o  (avg_valid)
  );

  assign above   = avg_valid && (avgMag > falseLockThreshold);
  assign below   = avg_valid && (avgMag < (falseLockThreshold >> 1));
  assign cnt_inc = cnt_q + 1'b1;

  // FALSE_LOCK is checked before lock loss so the reset pulse always completes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = '0;
    if (state_q == ST_FALSE_LOCK) begin
      if (pcnt_q == PULSE_LAST) begin
        cnt_d   = '0;
        state_d = carrierLock ? ST_RECOVER : ST_IDLE;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end else if (!carrierLock) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          state_d = ST_MONITOR;
        end
        ST_MONITOR: begin
          if (above) begin
            cnt_d   = CNT_W'(1);
            state_d = (DWELL_LAST == CNT_W'(1)) ? ST_FALSE_LOCK : ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (avg_valid) begin
            if (above) begin
              cnt_d = cnt_inc;
              if (cnt_inc == DWELL_LAST) state_d = ST_FALSE_LOCK;
            end else begin
              cnt_d   = '0;
              state_d = ST_MONITOR;
            end
          end
        end
        ST_RECOVER: begin
          if (avg_valid) begin
            if (below) begin
              cnt_d = cnt_inc;
              if (cnt_inc == DWELL_LAST) begin
                cnt_d   = '0;
                state_d = ST_MONITOR;
              end
            end else begin
              cnt_d = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    hfo_d = (state_d == ST_FALSE_LOCK) || (state_d == ST_RECOVER);
    lr_d  = (state_d == ST_FALSE_LOCK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      hfo_q   <= 1'b0;
      lr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      hfo_q   <= hfo_d;
      lr_q    <= lr_d;
    end
  end

  assign highFreqOffset = hfo_q;
  assign loopReset      = lr_q;

`ifdef FALSE_LOCK_STATS_EN
  logic [15:0] stats_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stats_q <= '0;
    end else if (clearStats) begin
      stats_q <= '0;
    end else if ((state_d == ST_FALSE_LOCK) && (state_q != ST_FALSE_LOCK) && (stats_q != 16'hFFFF)) begin
      stats_q <= stats_q + 16'd1;
    end
  end

  assign falseLockCount = stats_q;
`endif

endmodule

// File: tb/tb_false_lock_detector.sv
// Bench for false_lock_detector: sample-level reference model checked every cycle,
// plus directed literal checkpoints (filter steps, dwell, pulse length, recovery, lock loss, reset).
module tb_false_lock_detector;

  localparam int DWELL = 64;
  localparam int PULSE = 8;
  localparam int P_IDLE = 0, P_WATCH = 1, P_PULSE = 2, P_RECOVER = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sync;
  logic [15:0] freqError;
  logic        carrierLock;
  logic [15:0] falseLockAlpha;
  logic [15:0] falseLockThreshold;
  logic [15:0] avgMag;
  logic        highFreqOffset;
  logic        loopReset;
`ifdef FALSE_LOCK_STATS_EN
  logic        clearStats;
  logic [15:0] falseLockCount;
`endif

  false_lock_detector dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .sync               (sync),
    .freqError          (freqError),
    .carrierLock        (carrierLock),
    .falseLockAlpha     (falseLockAlpha),
    .falseLockThreshold (falseLockThreshold),
    .avgMag             (avgMag),
    .highFreqOffset     (highFreqOffset),
    .loopReset          (loopReset)
`ifdef FALSE_LOCK_STATS_EN
    ,
    .clearStats         (clearStats),
    .falseLockCount     (falseLockCount)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model (per-sample arithmetic) ----------------
  int  m_avg, m_diff, m_phase, m_streak, m_pulse_left, m_stats;
  bit  m_pend, m_valid;
  int  t_avg;
  bit  t_valid;
  longint t_sum;

  function automatic int absmag(input logic [15:0] e);
    int v;
    v = int'($signed(e));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  function automatic longint floordiv65536(input longint n);
    if (n >= 0) return n / 65536;
    return -((-n + 65535) / 65536);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_avg = 0; m_diff = 0; m_phase = P_IDLE; m_streak = 0;
      m_pulse_left = 0; m_stats = 0; m_pend = 0; m_valid = 0;
    end else begin
      t_avg   = m_avg;
      t_valid = m_valid;
`ifdef FALSE_LOCK_STATS_EN
      if (clearStats) m_stats = 0;
`endif
      if (m_phase == P_PULSE) begin
        m_pulse_left = m_pulse_left - 1;
        if (m_pulse_left == 0) begin
          m_phase  = carrierLock ? P_RECOVER : P_IDLE;
          m_streak = 0;
        end
      end else if (!carrierLock) begin
        m_phase = P_IDLE; m_streak = 0;
      end else if (m_phase == P_IDLE) begin
        m_phase = P_WATCH; m_streak = 0;
      end else if (t_valid && m_phase == P_WATCH) begin
        if (t_avg > int'(falseLockThreshold)) begin
          m_streak = m_streak + 1;
          if (m_streak == DWELL) begin
            m_phase = P_PULSE; m_pulse_left = PULSE;
`ifdef FALSE_LOCK_STATS_EN
            if (!clearStats && m_stats < 65535) m_stats = m_stats + 1;
`endif
          end
        end else m_streak = 0;
      end else if (t_valid && m_phase == P_RECOVER) begin
        if (t_avg < int'(falseLockThreshold) / 2) m_streak = m_streak + 1;
        else m_streak = 0;
        if (m_streak == DWELL) begin m_phase = P_WATCH; m_streak = 0; end
      end
      m_valid = m_pend;
      if (m_pend) begin
        t_sum = longint'(t_avg) + floordiv65536(longint'(m_diff) * longint'(falseLockAlpha));
        if (t_sum < 0) m_avg = 0;
        else if (t_sum > 65535) m_avg = 65535;
        else m_avg = int'(t_sum);
      end
      m_pend = sync;
      if (sync) m_diff = absmag(freqError) - t_avg;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cur_len = 0, last_len = 0, n_pulses = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic send(input int err);
    freqError = 16'(err);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  int pulses_before;

  initial begin
    reset_n = 1'b0; sync = 1'b0; freqError = '0; carrierLock = 1'b0;
    falseLockAlpha = '0; falseLockThreshold = 16'hFFFF;
`ifdef FALSE_LOCK_STATS_EN
    clearStats = 1'b0;
`endif
    fork
      forever begin
        @(negedge clk);
        if (reset_n) begin
          check("model_avgMag", int'(avgMag), m_avg);
          check("model_highFreqOffset", int'(highFreqOffset), int'(m_phase == P_PULSE || m_phase == P_RECOVER));
          check("model_loopReset", int'(loopReset), int'(m_phase == P_PULSE));
`ifdef FALSE_LOCK_STATS_EN
          check("model_falseLockCount", int'(falseLockCount), m_stats);
`endif
        end
        if (loopReset) cur_len++;
        else if (cur_len != 0) begin last_len = cur_len; n_pulses++; cur_len = 0; end
      end
      begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(negedge clk);
    check("reset_avgMag", int'(avgMag), 0);
    check("reset_hfo", int'(highFreqOffset), 0);
    check("reset_loopReset", int'(loopReset), 0);
    reset_n = 1'b1;
    carrierLock = 1'b1;
    falseLockAlpha = 16'h8000;
    repeat (2) @(negedge clk);

    send(1000); check("step1_avg", int'(avgMag), 500);
    send(1000); check("step2_avg", int'(avgMag), 750);
    send(1000); check("step3_avg", int'(avgMag), 875);
    falseLockAlpha = 16'hFFFF;
    send(-32768); check("most_neg_avg", int'(avgMag), 32766);
    falseLockAlpha = 16'h0000;
    send(5000); check("alpha0_freeze", int'(avgMag), 32766);
    check("thr_ffff_no_decl", int'(highFreqOffset), 0);

    // dwell abort after 63 qualifying samples, then a full declaration
    falseLockThreshold = 16'd200;
    falseLockAlpha = 16'hFFFF;
    repeat (63) send(1000);
    check("dwell63_hfo", int'(highFreqOffset), 0);
    send(0);
    check("abort_avg", int'(avgMag), 0);
    check("abort_hfo", int'(highFreqOffset), 0);
    pulses_before = n_pulses;
    repeat (63) send(1000);
    check("redwell63_hfo", int'(highFreqOffset), 0);
    send(1000);
    check("declare_hfo", int'(highFreqOffset), 1);
    check("declare_loopReset", int'(loopReset), 1);
    repeat (12) @(negedge clk);
    check("pulse_len", last_len, PULSE);
    check("pulse_count", n_pulses, pulses_before + 1);

    // recovery: between half-threshold and threshold holds, below clears
    repeat (20) send(150);
    check("hold_avg", int'(avgMag), 150);
    check("hold_hfo", int'(highFreqOffset), 1);
    repeat (63) send(50);
    check("recover63_hfo", int'(highFreqOffset), 1);
    send(50);
    check("recovered_hfo", int'(highFreqOffset), 0);

    // lock loss during dwell
    pulses_before = n_pulses;
    repeat (10) send(1000);
    carrierLock = 1'b0;
    repeat (2) @(negedge clk);
    check("lockloss_dwell_hfo", int'(highFreqOffset), 0);
    check("lockloss_dwell_pulses", n_pulses, pulses_before);
    carrierLock = 1'b1;
    repeat (3) @(negedge clk);

    // lock loss during the reset pulse
    repeat (64) send(1000);
    check("decl2_loopReset", int'(loopReset), 1);
    carrierLock = 1'b0;
    repeat (12) @(negedge clk);
    check("lockloss_pulse_len", last_len, PULSE);
    check("lockloss_pulse_hfo", int'(highFreqOffset), 0);
`ifdef FALSE_LOCK_STATS_EN
    check("stats_two", int'(falseLockCount), 2);
    clearStats = 1'b1;
    @(negedge clk);
    clearStats = 1'b0;
    check("stats_cleared", int'(falseLockCount), 0);
`endif

    // async reset in the middle of a pulse
    carrierLock = 1'b1;
    repeat (3) @(negedge clk);
    repeat (64) send(1000);
    check("decl3_loopReset", int'(loopReset), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_avgMag", int'(avgMag), 0);
    check("async_hfo", int'(highFreqOffset), 0);
    check("async_loopReset", int'(loopReset), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
